// File: rtl/arb_pkg.sv
// Shared definitions for the register write arbiter.
//   arb_state_t : arbiter FSM encoding (ARB = open round-robin, LOCKED = one owner)
//   WORD        : width of the shared register and of each requester's write data
package arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int WORD = 16;

endpackage

// File: rtl/register.sv
// Plain loadable register; holds its value until load is asserted.
//   clk  : rising-edge clock
//   load : capture in on this edge
//   in   : next value
//   out  : current contents
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // NOTE: no reset branch on the data flop; the owner clears it by driving
    // load=1, in=0 during reset, so the register stays a plain enable flop.
    always_ff @(posedge clk) begin
        if (load) begin
            // NOTE: non-blocking assignment for every flop, so all state in the
            // design updates together at the edge regardless of block order.
            out <= in;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing one WORD-bit register between NUM_REQ
// requesters, with an exclusive lock guarded by an idle watchdog.
//   clk          : system clock, all state on rising edge
//   reset        : synchronous, active-high; clears state and the register
//   req_valid    : requester i has a write pending
//   req_lock     : requester i wants/keeps exclusive ownership
//   req_data     : write data, requester i at [WORD*i +: WORD]
//   req_ready    : one-hot grant; write i happens on the edge where valid&ready
//   grant_id     : index of the granted requester (0 when none)
//   write_fire   : a write is accepted this cycle
//   reg_out      : current register contents, broadcast to all requesters
//   locked       : FSM is in LOCKED
//   lock_timeout : one-cycle pulse after a watchdog forced release
module reg_write_arbiter
    import arb_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  LOCK_MAX = 16,
    localparam int IDW      = $clog2(NUM_REQ),
    localparam int IDLE_W   = $clog2(LOCK_MAX)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_lock,
    input  logic [WORD*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IDW-1:0]          grant_id,
    output logic                    write_fire,
    output logic [WORD-1:0]         reg_out,
    output logic                    locked,
    output logic                    lock_timeout
);

    localparam logic [IDW:0]    NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0]  LAST_IDX  = IDW'(NUM_REQ - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_MAX - 1);

    arb_state_t        state, state_d;
    logic [IDW-1:0]    rr_ptr, rr_ptr_d;
    logic [IDW-1:0]    owner, owner_d;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_d;
    logic              timeout_d;
    logic [IDW:0]      pick;
    logic [WORD-1:0]   wdata;

    // Successor index, wrapping NUM_REQ-1 -> 0.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // First valid requester at or after ptr, wrapping. Result is {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     ptr);
        logic [IDW:0] sum;
        logic [IDW:0] res;
        res = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
            if (!res[IDW] && valid[sum[IDW-1:0]]) res = {1'b1, sum[IDW-1:0]};
        end
        return res;
    endfunction

    assign pick = rr_pick(req_valid, rr_ptr);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        owner_d    = owner;
        idle_cnt_d = idle_cnt;
        timeout_d  = 1'b0;
        req_ready  = '0;
        grant_id   = '0;
        write_fire = 1'b0;

        if (!reset) begin
            case (state)
                ARB: begin
                    if (pick[IDW]) begin
                        req_ready[pick[IDW-1:0]] = 1'b1;
                        grant_id   = pick[IDW-1:0];
                        write_fire = 1'b1;
                        rr_ptr_d   = next_idx(pick[IDW-1:0]);
                        if (req_lock[pick[IDW-1:0]]) begin
                            state_d    = LOCKED;
                            owner_d    = pick[IDW-1:0];
                            idle_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (req_valid[owner]) begin
                        req_ready[owner] = 1'b1;
                        grant_id   = owner;
                        write_fire = 1'b1;
                        idle_cnt_d = '0;
                    end
                    if (!req_lock[owner]) begin
                        state_d    = ARB;
                        rr_ptr_d   = next_idx(owner);
                        idle_cnt_d = '0;
                    end else if (!req_valid[owner]) begin
                        // Idle owner still holding the lock: watchdog.
                        // A write on this edge takes the branch above instead.
                        if (idle_cnt == IDLE_LAST) begin
                            state_d    = ARB;
                            rr_ptr_d   = next_idx(owner);
                            idle_cnt_d = '0;
                            timeout_d  = 1'b1;
                        end else begin
                            idle_cnt_d = idle_cnt + 1'b1;
                        end
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB;
            rr_ptr       <= '0;
            owner        <= '0;
            idle_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_d;
            rr_ptr       <= rr_ptr_d;
            owner        <= owner_d;
            idle_cnt     <= idle_cnt_d;
            lock_timeout <= timeout_d;
        end
    end

    // Data of the granted requester; req_ready is one-hot or zero.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) wdata = req_data[i*WORD +: WORD];
        end
    end

    register #(.WIDTH(WORD)) u_register (
        .clk  (clk),
        .load (write_fire | reset),
        .in   (reset ? '0 : wdata),
        .out  (reg_out)
    );

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NUM_REQ=4, LOCK_MAX=16).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_reg_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        write_fire;
    logic [15:0] reg_out;
    logic        locked;
    logic        lock_timeout;

    int n_checks = 0;
    int n_errors = 0;

    reg_write_arbiter #(.NUM_REQ(4), .LOCK_MAX(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_lock     (req_lock),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .grant_id     (grant_id),
        .write_fire   (write_fire),
        .reg_out      (reg_out),
        .locked       (locked),
        .lock_timeout (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs at the falling edge, settle, then return for checks.
    task automatic cyc(input logic rst, input logic [3:0] v, input logic [3:0] l);
        @(negedge clk);
        reset     = rst;
        req_valid = v;
        req_lock  = l;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [15:0] pat [4];
        logic [15:0] prev;
        pat[0] = 16'hAAAA; pat[1] = 16'h5555; pat[2] = 16'hFFFF; pat[3] = 16'h1234;
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_data  = {pat[3], pat[2], pat[1], pat[0]};

        // Reset behaviour: writes presented during reset are ignored.
        cyc(1'b1, 4'b1111, 4'b0000);
        check("rst_ready", req_ready, 0);
        check("rst_fire", write_fire, 0);
        check("rst_reg", reg_out, 16'h0000);
        check("rst_locked", locked, 0);
        cyc(1'b1, 4'b0010, 4'b0010);
        check("rst_ready2", req_ready, 0);

        // 1. Idle after reset.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'b0000, 4'b0000);
            check("idle_ready", req_ready, 0);
            check("idle_fire", write_fire, 0);
            check("idle_reg", reg_out, 16'h0000);
            check("idle_locked", locked, 0);
        end

        // 2. All valid, no lock: 0,1,2,3 in order, reg_out one cycle behind.
        prev = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'b1111, 4'b0000);
            check("rr_gid", grant_id, k);
            check("rr_ready", req_ready, 32'(1 << k));
            check("rr_fire", write_fire, 1);
            check("rr_reg", reg_out, prev);
            prev = pat[k];
        end
        cyc(1'b0, 4'b0000, 4'b0000);
        check("rr_reg_last", reg_out, 16'h1234);
        check("rr_none", write_fire, 0);

        // 3. Lock by requester 1 while others are valid.
        cyc(1'b0, 4'b0001, 4'b0000);
        check("l3_g0", grant_id, 0);
        cyc(1'b0, 4'b1111, 4'b0010);
        check("l3_g1", req_ready, 4'b0010);
        check("l3_reg", reg_out, 16'hAAAA);
        check("l3_unlocked", locked, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'b1111, 4'b0010);
            check("l3_only1", req_ready, 4'b0010);
            check("l3_locked", locked, 1);
        end
        cyc(1'b0, 4'b1101, 4'b0000);
        check("l3_drop_ready", req_ready, 0);
        check("l3_drop_fire", write_fire, 0);
        cyc(1'b0, 4'b1101, 4'b0000);
        check("l3_rel_locked", locked, 0);
        check("l3_next_g2", grant_id, 2);
        check("l3_next_ready", req_ready, 4'b0100);
        cyc(1'b0, 4'b0000, 4'b0000);
        check("l3_reg2", reg_out, 16'hFFFF);

        // 4. Watchdog: owner 3 idle with lock held for LOCK_MAX cycles.
        cyc(1'b0, 4'b1000, 4'b1000);
        check("wd_grant", grant_id, 3);
        for (int j = 1; j <= 16; j++) begin
            cyc(1'b0, 4'b0000, 4'b1000);
            check("wd_hold_locked", locked, 1);
            check("wd_hold_to", lock_timeout, 0);
        end
        cyc(1'b0, 4'b0000, 4'b1000);
        check("wd_released", locked, 0);
        check("wd_pulse", lock_timeout, 1);
        check("wd_reg", reg_out, 16'h1234);
        cyc(1'b0, 4'b0000, 4'b0000);
        check("wd_pulse_end", lock_timeout, 0);
        cyc(1'b0, 4'b1111, 4'b0000);
        check("wd_ptr", grant_id, 0);

        // 5. Owner 2 writes on the would-be timeout edge.
        cyc(1'b0, 4'b0100, 4'b0100);
        check("ws_grant", req_ready, 4'b0100);
        for (int j = 1; j <= 15; j++) begin
            cyc(1'b0, 4'b0000, 4'b0100);
            check("ws_hold", locked, 1);
        end
        req_data[32 +: 16] = 16'hBEEF;
        cyc(1'b0, 4'b0100, 4'b0100);
        check("ws_ready", req_ready, 4'b0100);
        check("ws_fire", write_fire, 1);
        cyc(1'b0, 4'b0000, 4'b0100);
        check("ws_reg", reg_out, 16'hBEEF);
        check("ws_locked", locked, 1);
        check("ws_no_to", lock_timeout, 0);
        cyc(1'b0, 4'b0000, 4'b0100);
        check("ws_no_to2", lock_timeout, 0);
        check("ws_locked2", locked, 1);

        // 6. Reset mid-lock with the owner presenting a write.
        req_data[32 +: 16] = 16'h7777;
        cyc(1'b1, 4'b0100, 4'b0100);
        check("r6_ready", req_ready, 0);
        check("r6_fire", write_fire, 0);
        cyc(1'b1, 4'b0100, 4'b0100);
        check("r6_reg", reg_out, 16'h0000);
        check("r6_locked", locked, 0);
        check("r6_to", lock_timeout, 0);
        cyc(1'b0, 4'b1111, 4'b0000);
        check("r6_ptr", grant_id, 0);
        check("r6_ready0", req_ready, 4'b0001);
        cyc(1'b0, 4'b0000, 4'b0000);
        check("r6_reg_after", reg_out, 16'hAAAA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
